axis_width_downsizer: RTL and testbench
=======================================

Name: axis_width_downsizer

Overview:
Stage directly downstream of the datapath's 64-bit AXI-Stream FIFO. It takes each wide beat from the FIFO master port and emits it as RATIO narrow beats toward the 32-bit core-side interface. Frame boundaries are preserved: tlast is asserted only on the final narrow slice of a wide beat that carried tlast. Full handshake with backpressure; one wide beat is buffered internally.

Parameters:
S_DATA_WIDTH, 64, input (FIFO-side) data width; must be an integer multiple of M_DATA_WIDTH.
M_DATA_WIDTH, 32, output data width.
RATIO, S_DATA_WIDTH/M_DATA_WIDTH, derived localparam; number of narrow beats per wide beat; must be >=2.
CNT_WIDTH, $clog2(RATIO), derived localparam; slice counter width.

Ports:
clk  input  1  single clock for all logic.
rst  input  1  synchronous, active-high reset.
s_axis_tdata  input  S_DATA_WIDTH  wide beat from FIFO.
s_axis_tlast  input  1  end of frame on the wide beat.
s_axis_tvalid  input  1  wide beat valid.
s_axis_tready  output  1  downsizer can accept a wide beat.
m_axis_tdata  output  M_DATA_WIDTH  narrow slice.
m_axis_tlast  output  1  end of frame; only on the last slice.
m_axis_tvalid  output  1  narrow slice valid.
m_axis_tready  input  1  downstream accept.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- State: data_reg (S_DATA_WIDTH), last_reg, valid_reg, cnt (CNT_WIDTH).
- Reset: data_reg=0, last_reg=0, valid_reg=0, cnt=0.
  - Outputs after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=1.
- FSM: EMPTY (valid_reg=0) and SLICING (valid_reg=1, cnt=0..RATIO-1).
- s_axis_tready = !valid_reg || (m_axis_tready && cnt==RATIO-1). This is combinational from m_axis_tready, so wide beats can be accepted back-to-back.
- Input accept (s_axis_tvalid && s_axis_tready):
  - data_reg<=s_axis_tdata, last_reg<=s_axis_tlast, valid_reg<=1, cnt<=0.
  - This takes priority over the completion clear in the same cycle.
- m_axis_tvalid = valid_reg.
- m_axis_tdata = data_reg[cnt*M_DATA_WIDTH +: M_DATA_WIDTH]. Default order is LSW first.
- m_axis_tlast = valid_reg && last_reg && (cnt==RATIO-1).
- Output handshake (m_axis_tvalid && m_axis_tready):
  - If cnt<RATIO-1: cnt<=cnt+1.
  - Else: valid_reg<=0 and cnt<=0, unless a new input is accepted in the same cycle.
- Latency: first slice is valid 1 cycle after the wide beat is accepted.
- Throughput: 1 narrow beat per cycle with no bubble between wide beats, given upstream valid and downstream ready.
- Stall (m_axis_tready=0): m_axis_tdata, m_axis_tlast and m_axis_tvalid stay stable; cnt holds; s_axis_tready=0 while valid_reg=1.
- Empty: m_axis_tvalid=0; m_axis_tdata holds the last data_reg slice (don't-care to downstream).
- No valid beat is ever dropped or duplicated.
- tlast on a non-final wide beat produces no m_axis_tlast.
- Reset mid-frame: buffered beat discarded, cnt cleared; downstream sees m_axis_tvalid drop the next cycle.
- Deasserting s_axis_tvalid without a handshake is tolerated; nothing is latched.

Optional Feature:
Macro AXIS_DOWNSIZE_MSW_FIRST_EN.
- Defined: slice order reversed; m_axis_tdata = data_reg[(RATIO-1-cnt)*M_DATA_WIDTH +: M_DATA_WIDTH], so the most significant word goes first. tlast remains on the final slice, now the LSW.
- Undefined: LSW-first order as above.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> s_axis_tready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- Single beat: tdata=0x11223344_55667788, tlast=1, m_axis_tready=1 -> 0x55667788 (tlast=0), then 0x11223344 (tlast=1) on consecutive cycles. With macro defined: 0x11223344 then 0x55667788, tlast on the second.
- Streaming: 4 wide beats, 0x0000000A_00000009 .. 0x00000010_0000000F, tlast on the 4th, both sides always ready -> 8 narrow beats 0x9..0x10 with no gaps, tlast only on 0x10, s_axis_tready pattern 1,0,1,0.
- Backpressure: m_axis_tready toggled 1,0,0,1,... -> outputs stable while stalled, every slice appears exactly once in order, s_axis_tready=0 until the last slice handshakes.
- Non-final tlast: wide beat with tlast=0 -> both slices have m_axis_tlast=0.
- Mid-frame reset: rst=1 after the first slice of 0xDEADBEEF_CAFEF00D -> m_axis_tvalid=0 the next cycle, 0xDEADBEEF is never emitted, s_axis_tready=1.

Source files
------------

// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: splits each buffered wide beat into RATIO narrow beats.
// Optional macro AXIS_DOWNSIZE_MSW_FIRST_EN emits the most significant word first.
module axis_width_downsizer #(
    parameter int S_DATA_WIDTH = 64,
    parameter int M_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int RATIO     = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(RATIO);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RATIO - 1);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid never waits on ready, and once raised data/last hold
    // until that transfer. s_axis_tready looks at m_axis_tready so a new wide
    // beat can load in the same cycle the final slice leaves.

    typedef enum logic {
        EMPTY   = 1'b0,
        SLICING = 1'b1
    } state_t;

    // state_q is the FSM state; valid_reg is simply state_q == SLICING.
    state_t                  state_q, state_d;
    logic [S_DATA_WIDTH-1:0] data_reg, data_d;
    logic                    last_reg, last_d;
    logic [CNT_WIDTH-1:0]    cnt, cnt_d;
    logic                    valid_reg;
    logic                    s_fire;
    logic                    m_fire;
    logic [M_DATA_WIDTH-1:0] slice;

    assign valid_reg = (state_q == SLICING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            data_reg <= '0;
            last_reg <= 1'b0;
            cnt      <= '0;
        end else begin
            state_q  <= state_d;
            data_reg <= data_d;
            last_reg <= last_d;
            cnt      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_reg;
        last_d  = last_reg;
        cnt_d   = cnt;

        s_axis_tready = !valid_reg || (m_axis_tready && (cnt == CNT_LAST));
        s_fire        = s_axis_tvalid && s_axis_tready;
        m_fire        = valid_reg && m_axis_tready;

        if (m_fire) begin
            if (cnt != CNT_LAST) begin
                cnt_d = cnt + CNT_WIDTH'(1);
            end else begin
                state_d = EMPTY;
                cnt_d   = '0;
            end
        end

        // Loading a new wide beat overrides the completion clear above.
        if (s_fire) begin
            state_d = SLICING;
            data_d  = s_axis_tdata;
            last_d  = s_axis_tlast;
            cnt_d   = '0;
        end
    end

    // Slice mux written as a compare-per-slot so no multiply on cnt is needed.
    always_comb begin
        slice = data_reg[M_DATA_WIDTH-1:0];
        for (int i = 0; i < RATIO; i++) begin
            if (cnt == CNT_WIDTH'(i)) begin
`ifdef AXIS_DOWNSIZE_MSW_FIRST_EN
                slice = data_reg[(RATIO-1-i)*M_DATA_WIDTH +: M_DATA_WIDTH];
`else
                slice = data_reg[i*M_DATA_WIDTH +: M_DATA_WIDTH];
`endif
            end
        end
    end

    assign m_axis_tdata  = slice;
    assign m_axis_tvalid = valid_reg;
    assign m_axis_tlast  = valid_reg && last_reg && (cnt == CNT_LAST);

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Testbench for axis_width_downsizer: directed scenarios plus randomized traffic
// scored against a queue of expected narrow beats built from the wide beats sent.
module tb_axis_width_downsizer;

    localparam int SW    = 64;
    localparam int MW    = 32;
    localparam int RATIO = SW / MW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [MW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Expected narrow beats, {tlast, tdata}, oldest first.
    logic [MW:0] exp_q[$];

    axis_width_downsizer #(
        .S_DATA_WIDTH(SW),
        .M_DATA_WIDTH(MW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tlast (s_tlast),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a wide beat becomes RATIO words in send order, tlast on the final one.
    function automatic void model_push(input logic [SW-1:0] d, input logic l);
        int          idx;
        logic [MW-1:0] w;
        for (int i = 0; i < RATIO; i++) begin
`ifdef AXIS_DOWNSIZE_MSW_FIRST_EN
            idx = RATIO - 1 - i;
`else
            idx = i;
`endif
            w = MW'(d >> (idx * MW));
            exp_q.push_back({l && (i == RATIO - 1), w});
        end
    endfunction

    // Drive one cycle's inputs after the falling edge and let outputs settle.
    task automatic drive(input logic sv, input logic [SW-1:0] sd, input logic sl, input logic mr);
        @(negedge clk);
        s_tvalid = sv;
        s_tdata  = sd;
        s_tlast  = sl;
        m_tready = mr;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_q.delete();
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_s_tready got=%b exp=1", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_m_tlast got=%b exp=0", m_tlast); end
        checks++; if (m_tdata !== '0) begin failures++; $display("FAIL reset_m_tdata got=%h exp=0", m_tdata); end
    endtask

    task automatic test_single_beat;
        logic [MW-1:0] w0, w1;
`ifdef AXIS_DOWNSIZE_MSW_FIRST_EN
        w0 = 32'h11223344; w1 = 32'h55667788;
`else
        w0 = 32'h55667788; w1 = 32'h11223344;
`endif
        drive(1'b1, 64'h11223344_55667788, 1'b1, 1'b1);
        checks++; if (s_tready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", s_tready); end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== w0 || m_tlast !== 1'b0) begin
            failures++; $display("FAIL single_slice0 got=%b/%h/%b exp=1/%h/0", m_tvalid, m_tdata, m_tlast, w0);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== w1 || m_tlast !== 1'b1) begin
            failures++; $display("FAIL single_slice1 got=%b/%h/%b exp=1/%h/1", m_tvalid, m_tdata, m_tlast, w1);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            failures++; $display("FAIL single_drain got valid=%b ready=%b exp valid=0 ready=1", m_tvalid, s_tready);
        end
    endtask

    task automatic test_streaming;
        int          k;
        logic [SW-1:0] beat;
        logic [MW:0] e;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            beat = {32'(10 + 2 * k), 32'(9 + 2 * k)};
            drive(k < 4, beat, k == 3, 1'b1);
            if (c < 8) begin
                checks++; if (s_tready !== (c % 2 == 0)) begin
                    failures++; $display("FAIL stream_s_tready cycle=%0d got=%b exp=%b", c, s_tready, (c % 2 == 0));
                end
            end
            if (c >= 1) begin
                checks++; if (m_tvalid !== 1'b1) begin failures++; $display("FAIL stream_gap cycle=%0d got=%b exp=1", c, m_tvalid); end
            end
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stream_extra got=%h exp=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== e) begin
                        failures++; $display("FAIL stream_data got=%b/%h exp=%b/%h", m_tlast, m_tdata, e[MW], e[MW-1:0]);
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                model_push(beat, k == 3);
                k++;
            end
        end
        checks++; if (k != 4 || exp_q.size() != 0) begin
            failures++; $display("FAIL stream_count got accepted=%0d left=%0d exp accepted=4 left=0", k, exp_q.size());
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_non_final_tlast;
        drive(1'b1, 64'hA5A5A5A5_5A5A5A5A, 1'b0, 1'b1);
        for (int i = 0; i < RATIO; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            checks++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b0) begin
                failures++; $display("FAIL nonfinal_tlast slice=%0d got valid=%b last=%b exp valid=1 last=0", i, m_tvalid, m_tlast);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL nonfinal_drain got=%b exp=0", m_tvalid); end
    endtask

    task automatic test_backpressure;
        logic [SW-1:0] beats[8];
        logic          lasts[8];
        int            sent, cyc;
        logic          sv, mr, exp_rdy, stalled;
        logic [MW:0]   prev, e;
        for (int i = 0; i < 8; i++) begin
            beats[i] = {$urandom, $urandom};
            lasts[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; cyc = 0; stalled = 1'b0; prev = '0;
        while ((sent < 8 || exp_q.size() != 0) && cyc < 400) begin
            sv = (sent < 8) && ($urandom_range(0, 3) != 0);
            case (cyc)
                0: mr = 1'b1;
                1: mr = 1'b0;
                2: mr = 1'b0;
                3: mr = 1'b1;
                default: mr = 1'($urandom_range(0, 1));
            endcase
            drive(sv, sv ? beats[sent] : {$urandom, $urandom}, sv ? lasts[sent] : 1'($urandom_range(0, 1)), mr);
            exp_rdy = (exp_q.size() == 0) || (mr && exp_q.size() == 1);
            checks++; if (s_tready !== exp_rdy) begin
                failures++; $display("FAIL bp_s_tready cycle=%0d got=%b exp=%b", cyc, s_tready, exp_rdy);
            end
            checks++; if (m_tvalid !== (exp_q.size() != 0)) begin
                failures++; $display("FAIL bp_m_tvalid cycle=%0d got=%b exp=%b", cyc, m_tvalid, exp_q.size() != 0);
            end
            if (stalled) begin
                checks++; if ({m_tlast, m_tdata} !== prev || m_tvalid !== 1'b1) begin
                    failures++; $display("FAIL bp_stall_stable cycle=%0d got=%b/%h exp=%b/%h", cyc, m_tlast, m_tdata, prev[MW], prev[MW-1:0]);
                end
            end
            if (m_tvalid && mr) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL bp_extra got=%h exp=none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tlast, m_tdata} !== e) begin
                        failures++; $display("FAIL bp_data got=%b/%h exp=%b/%h", m_tlast, m_tdata, e[MW], e[MW-1:0]);
                    end
                end
            end
            if (sv && s_tready) begin
                model_push(beats[sent], lasts[sent]);
                sent++;
            end
            stalled = m_tvalid && !mr;
            prev = {m_tlast, m_tdata};
            cyc++;
        end
        checks++; if (sent != 8 || exp_q.size() != 0) begin
            failures++; $display("FAIL bp_timeout got sent=%0d left=%0d exp sent=8 left=0", sent, exp_q.size());
        end
        exp_q.delete();
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_frame_reset;
        logic [MW:0] e;
        logic [MW-1:0] second;
        drive(1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1);
        model_push(64'hDEADBEEF_CAFEF00D, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        e = exp_q.pop_front();
        second = exp_q[0][MW-1:0];
        checks++; if (m_tvalid !== 1'b1 || m_tdata !== e[MW-1:0]) begin
            failures++; $display("FAIL mfr_first got=%b/%h exp=1/%h", m_tvalid, m_tdata, e[MW-1:0]);
        end
        @(negedge clk);
        rst = 1'b1;
        m_tready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_tready = 1'b1;
        #1;
        exp_q.delete();
        checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1 || m_tlast !== 1'b0) begin
            failures++; $display("FAIL mfr_after got valid=%b ready=%b last=%b exp 0/1/0", m_tvalid, s_tready, m_tlast);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            checks++; if (m_tvalid !== 1'b0 || m_tdata === second) begin
                failures++; $display("FAIL mfr_no_emit cycle=%0d got=%b/%h exp=0/not %h", i, m_tvalid, m_tdata, second);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_streaming();
        test_non_final_tlast();
        test_backpressure();
        test_mid_frame_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
